// File: rtl/mux_pkg.sv
// mux_pkg: shared arbitration mode constants and channel-index width helper
package mux_pkg;
    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: combinational round-robin grant starting after the last winner
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx
);
    logic [CH_W-1:0] c;
    always_comb begin
        grant = '0;
        idx = '0;
        c = '0;
        // farthest candidate first so the nearest requester after last overwrites
        for (int i = NUM_CH; i >= 1; i--) begin
            c = CH_W'((int'(last) + i) % NUM_CH);
            if (req[c]) begin
                grant = '0;
                grant[c] = 1'b1;
                idx = c;
            end
        end
    end
endmodule

// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: registered N-to-1 valid/ready mux with select or round-robin arbitration
module mux_rr_nto1
    import mux_pkg::*;
#(
    parameter int DATA_W = 2,
    parameter int NUM_CH = 4,
    parameter int MODE = MUX_MODE_RR,
    localparam int CH_W = ch_w(NUM_CH)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic [NUM_CH-1:0]        i_valid,
    output logic [NUM_CH-1:0]        o_ready,
    input  logic [CH_W-1:0]          i_sel,
    output logic [DATA_W-1:0]        o_data,
    output logic [CH_W-1:0]          o_ch,
    output logic                     o_valid,
    input  logic                     i_ready
);
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   idx;
    logic              load_en;
    logic              take;

    assign load_en = !o_valid || i_ready;
    assign o_ready = i_reset ? '0 : grant & {NUM_CH{load_en}};
    assign take    = |o_ready;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [CH_W-1:0] last;
            rr_arbiter_n #(.NUM_CH(NUM_CH)) u_arb (
                .req(i_valid),
                .last(last),
                .grant(grant),
                .idx(idx)
            );
            // priority moves only on an actual transfer
            always_ff @(posedge i_clk) begin
                if (i_reset) last <= CH_W'(NUM_CH - 1);
                else if (take) last <= idx;
            end
        end else begin : g_sel
            always_comb begin
                grant = '0;
                for (int k = 0; k < NUM_CH; k++) grant[k] = (int'(i_sel) == k) && i_valid[k];
            end
            assign idx = i_sel;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
        end else if (load_en) begin
            o_valid <= take;
            if (take) begin
                o_data <= i_data[int'(idx)*DATA_W +: DATA_W];
                o_ch   <= idx;
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_nto1.sv
// tb_mux_rr_nto1: RR and SEL instances checked against a behavioural model
module tb_mux_rr_nto1;
    import mux_pkg::*;
    logic       i_clk = 0;
    logic       i_reset;
    logic [7:0] i_data;
    logic [3:0] i_valid;
    logic [1:0] i_sel;
    logic       i_ready;
    logic [3:0] r_ready, s_ready;
    logic [1:0] r_data, s_data, r_ch, s_ch;
    logic       r_valid, s_valid;
    int errors = 0;
    int checks = 0;
    int er_valid, er_data, er_ch, er_last;
    int es_valid, es_data, es_ch;

    always #5 i_clk = ~i_clk;

    mux_rr_nto1 #(.DATA_W(2), .NUM_CH(4), .MODE(MUX_MODE_RR)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
        .o_ready(r_ready), .i_sel(i_sel), .o_data(r_data), .o_ch(r_ch),
        .o_valid(r_valid), .i_ready(i_ready)
    );
    mux_rr_nto1 #(.DATA_W(2), .NUM_CH(4), .MODE(MUX_MODE_SEL)) dut_sel (
        .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
        .o_ready(s_ready), .i_sel(i_sel), .o_data(s_data), .o_ch(s_ch),
        .o_valid(s_valid), .i_ready(i_ready)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int payload(input logic [7:0] d, input int ch);
        return int'((d >> (2 * ch)) & 8'h3);
    endfunction

    task automatic model_reset();
        er_valid = 0; er_data = 0; er_ch = 0; er_last = 3;
        es_valid = 0; es_data = 0; es_ch = 0;
    endtask

    task automatic step(input logic rst, input logic [3:0] v, input logic [7:0] d,
                        input logic [1:0] s, input logic rdy);
        int g_rr, g_sel;
        i_reset = rst; i_valid = v; i_data = d; i_sel = s; i_ready = rdy;
        #2;
        g_rr = -1;
        if (!rst && (er_valid == 0 || rdy))
            for (int i = 1; i <= 4; i++)
                if (g_rr < 0 && v[(er_last + i) % 4]) g_rr = (er_last + i) % 4;
        g_sel = (!rst && (es_valid == 0 || rdy) && v[s]) ? int'(s) : -1;
        check("rr_ready", int'(r_ready), g_rr < 0 ? 0 : (1 << g_rr));
        check("sel_ready", int'(s_ready), g_sel < 0 ? 0 : (1 << g_sel));
        @(posedge i_clk);
        #1;
        if (rst) model_reset();
        else begin
            if (er_valid == 0 || rdy) begin
                er_valid = (g_rr >= 0) ? 1 : 0;
                if (g_rr >= 0) begin er_data = payload(d, g_rr); er_ch = g_rr; er_last = g_rr; end
            end
            if (es_valid == 0 || rdy) begin
                es_valid = (g_sel >= 0) ? 1 : 0;
                if (g_sel >= 0) begin es_data = payload(d, g_sel); es_ch = g_sel; end
            end
        end
        check("rr_valid", int'(r_valid), er_valid);
        check("rr_data", int'(r_data), er_data);
        check("rr_ch", int'(r_ch), er_ch);
        check("sel_valid", int'(s_valid), es_valid);
        check("sel_data", int'(s_data), es_data);
        check("sel_ch", int'(s_ch), es_ch);
    endtask

    initial begin
        model_reset();
        i_reset = 1; i_valid = 0; i_data = 0; i_sel = 0; i_ready = 0;
        @(posedge i_clk);
        #1;
        repeat (2) step(1, 4'b1111, 8'hE4, 2'd0, 1);
        repeat (5) step(0, 4'b1111, 8'hE4, 2'd0, 1);
        repeat (4) step(0, 4'b1010, 8'hE4, 2'd1, 1);
        step(0, 4'b0001, 8'hE4, 2'd0, 1);
        step(0, 4'b0100, 8'hE4, 2'd2, 1);
        repeat (3) step(0, 4'b1111, 8'hE4, 2'd2, 0);
        step(0, 4'b1111, 8'hE4, 2'd3, 1);
        step(0, 4'b0010, 8'h30, 2'd2, 1);
        step(0, 4'b0100, 8'h30, 2'd2, 1);
        step(0, 4'b1111, 8'h9C, 2'd1, 0);
        step(1, 4'b1111, 8'h9C, 2'd1, 0);
        step(0, 4'b1111, 8'h9C, 2'd1, 1);
        repeat (400) begin
            step($urandom_range(0, 49) == 0, 4'($urandom), 8'($urandom),
                 2'($urandom), $urandom_range(0, 3) != 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
